// File: rtl/ub_pkg.sv
// Shared definitions for the unified-buffer host loader: FSM states and command opcodes.
package ub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_RX,
    LD_WR,
    LD_ACK,
    DP_RD,
    DP_ACK,
    DP_TX,
    FINISH
  } state_t;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

endpackage

// File: rtl/ub_host_loader.sv
// Moves host byte streams into/out of the unified buffer, one byte per buffer access,
// low byte (section 0) then high byte (section 1) for each word in ascending address order.
module ub_host_loader
  import ub_pkg::*;
#(
  parameter int BUFFER_SIZE     = 1024,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [ADDRESS_SIZE-1:0]    cmd_base,
  input  logic [ADDRESS_SIZE:0]      cmd_len,
  input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [FIFO_DATA_WIDTH-1:0] tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       ub_we,
  output logic                       ub_re,
  output logic                       ub_fifo_en,
  output logic                       ub_compute_en,
  output logic                       ub_section,
  output logic [ADDRESS_SIZE-1:0]    ub_address,
  output logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in,
  input  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out,
  input  logic                       ub_done,
  output logic                       busy,
  output logic                       cmd_done,
  output logic                       cmd_err
);

  state_t                     state, state_n;
  logic [ADDRESS_SIZE-1:0]    addr_n;
  logic                       sec_n;
  logic [ADDRESS_SIZE:0]      words_left, words_left_n;
  logic [FIFO_DATA_WIDTH-1:0] wbyte_n, txd_n;
  logic                       done_n, err_n;
  logic [ADDRESS_SIZE+1:0]    cmd_end;
  logic                       last_byte;

  assign ub_compute_en = 1'b0;
  assign cmd_end       = (ADDRESS_SIZE+2)'(cmd_base) + (ADDRESS_SIZE+2)'(cmd_len);
  assign last_byte     = ub_section && (words_left == (ADDRESS_SIZE+1)'(1));

  always_comb begin
    state_n      = state;
    addr_n       = ub_address;
    sec_n        = ub_section;
    words_left_n = words_left;
    wbyte_n      = ub_fifo_in;
    txd_n        = tx_data;
    done_n       = 1'b0;
    err_n        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_end > (ADDRESS_SIZE+2)'(BUFFER_SIZE)) begin
            err_n = 1'b1;
          end else if (cmd_len == '0) begin
            done_n = 1'b1;
          end else begin
            addr_n       = cmd_base;
            sec_n        = 1'b0;
            words_left_n = cmd_len;
            state_n      = (cmd_op == OP_DUMP) ? DP_RD : LD_RX;
          end
        end
      end
      LD_RX: begin
        if (rx_valid && rx_ready) begin
          wbyte_n = rx_data;
          state_n = LD_WR;
        end
      end
      LD_WR: state_n = LD_ACK;
      LD_ACK: begin
        if (ub_done) begin
          if (last_byte) begin
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n = LD_RX;
            sec_n   = ~ub_section;
            if (ub_section) begin
              addr_n       = ub_address + 1'b1;
              words_left_n = words_left - 1'b1;
            end
          end
        end
      end
      DP_RD: state_n = DP_ACK;
      DP_ACK: begin
        if (ub_done) begin
          txd_n   = ub_fifo_out;
          state_n = DP_TX;
        end
      end
      DP_TX: begin
        if (tx_ready) begin
          if (last_byte) begin
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n = DP_RD;
            sec_n   = ~ub_section;
            if (ub_section) begin
              addr_n       = ub_address + 1'b1;
              words_left_n = words_left - 1'b1;
            end
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes and handshake flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ub_address <= '0;
      ub_section <= 1'b0;
      words_left <= '0;
      ub_fifo_in <= '0;
      tx_data    <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      ub_we      <= 1'b0;
      ub_re      <= 1'b0;
      ub_fifo_en <= 1'b0;
    end else begin
      state      <= state_n;
      ub_address <= addr_n;
      ub_section <= sec_n;
      words_left <= words_left_n;
      ub_fifo_in <= wbyte_n;
      tx_data    <= txd_n;
      cmd_done   <= done_n;
      cmd_err    <= err_n;
      busy       <= (state_n != IDLE);
      cmd_ready  <= (state_n == IDLE);
      rx_ready   <= (state_n == LD_RX);
      tx_valid   <= (state_n == DP_TX);
      ub_we      <= (state_n == LD_WR);
      ub_re      <= (state_n == DP_RD);
      ub_fifo_en <= (state_n == LD_WR) || (state_n == DP_RD);
    end
  end

endmodule

// File: tb/tb_ub_host_loader.sv
// Self-checking bench for ub_host_loader: buffer model, stream source/sink and a byte-level expectation model.
module tb_ub_host_loader;
  import ub_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [9:0]  cmd_base = '0;
  logic [10:0] cmd_len = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_section;
  logic [9:0]  ub_address;
  logic [7:0]  ub_fifo_in;
  logic [7:0]  ub_fifo_out = '0;
  logic        ub_done = 1'b0;
  logic        busy, cmd_done, cmd_err;

  ub_host_loader #(.BUFFER_SIZE(1024), .FIFO_DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ub_we(ub_we), .ub_re(ub_re), .ub_fifo_en(ub_fifo_en),
    .ub_compute_en(ub_compute_en), .ub_section(ub_section),
    .ub_address(ub_address), .ub_fifo_in(ub_fifo_in),
    .ub_fifo_out(ub_fifo_out), .ub_done(ub_done),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected behaviour expressed as byte streams indexed by addr*2+section.
  typedef struct packed {
    logic [9:0] a;
    logic       s;
    logic [7:0] d;
  } wr_t;

  logic [7:0]  model_mem [0:2047];
  logic [7:0]  bm_mem    [0:2047];
  wr_t         exp_wr[$];
  logic [10:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_seen[$];

  int   we_count = 0, re_count = 0, done_seen = 0, err_seen = 0;
  logic [9:0] last_wa = '0;
  logic       last_ws = 1'b0;
  int   done_delay = 1, bm_cnt = 0, overlap = 0, stall = 0, stall_ctr = 0;
  logic outstanding = 1'b0;
  logic rx_hs, tx_hs;

  // Buffer model: stores/returns bytes and answers each strobe with a one-cycle ub_done.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ub_done     = 1'b0;
      bm_cnt      = 0;
      outstanding = 1'b0;
    end else begin
      if (ub_done) begin
        ub_done     = 1'b0;
        outstanding = 1'b0;
      end
      if (bm_cnt > 0) begin
        bm_cnt--;
        if (bm_cnt == 0) ub_done = 1'b1;
      end
      if (ub_we || ub_re) begin
        if (outstanding) overlap++;
        outstanding = 1'b1;
        bm_cnt      = done_delay;
        if (ub_we) bm_mem[{ub_address, ub_section}] = ub_fifo_in;
        else       ub_fifo_out = bm_mem[{ub_address, ub_section}];
      end
    end
  end

  // Stream source and stalling sink.
  always begin
    @(negedge clk);
    rx_hs = rx_valid && rx_ready;
    tx_hs = tx_valid && tx_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      rx_valid  = 1'b0;
      tx_ready  = 1'b0;
      stall_ctr = 0;
    end else begin
      if (rx_hs && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_valid = (rx_q.size() > 0);
      rx_data  = rx_valid ? rx_q[0] : 8'h00;
      if (tx_hs) begin
        stall_ctr = 0;
        tx_ready  = 1'b0;
      end else if (tx_valid) begin
        if (stall_ctr < stall) begin
          stall_ctr++;
          tx_ready = 1'b0;
        end else begin
          tx_ready = 1'b1;
        end
      end else begin
        tx_ready = 1'b0;
      end
    end
  end

  // Compare process: every cycle outside reset, checks outputs against the expectation queues.
  logic       prev_txv = 1'b0, prev_hs = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  logic [7:0] prev_txd = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_txv = 1'b0; prev_hs = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
    end else begin
      check("we_re_exclusive", 32'(ub_we & ub_re), 32'(0));
      check("compute_en", 32'(ub_compute_en), 32'(0));
      check("fifo_en", 32'(ub_fifo_en), 32'(ub_we | ub_re));
      check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
      if (ub_we) begin
        we_count++;
        last_wa = ub_address;
        last_ws = ub_section;
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got write addr %0d sec %0d, expected none", ub_address, ub_section);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(ub_address), 32'(e.a));
          check("wr_sec", 32'(ub_section), 32'(e.s));
          check("wr_data", 32'(ub_fifo_in), 32'(e.d));
        end
      end
      if (ub_re) begin
        re_count++;
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got read addr %0d sec %0d, expected none", ub_address, ub_section);
        end else begin
          logic [10:0] r;
          r = exp_rd.pop_front();
          check("rd_addr_sec", 32'({ub_address, ub_section}), 32'(r));
        end
      end
      if (tx_valid && prev_txv && !prev_hs) check("tx_stable", 32'(tx_data), 32'(prev_txd));
      if (tx_valid && tx_ready) begin
        tx_seen.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
      end
      if (outstanding) begin
        check("rx_ready_wait", 32'(rx_ready), 32'(0));
        check("tx_valid_wait", 32'(tx_valid), 32'(0));
      end
      if (cmd_done) begin
        done_seen++;
        check("done_width", 32'(prev_done), 32'(0));
      end
      if (cmd_err) begin
        err_seen++;
        check("err_width", 32'(prev_err), 32'(0));
        check("ready_with_err", 32'(cmd_ready), 32'(1));
      end
      prev_txv  = tx_valid;
      prev_hs   = tx_valid && tx_ready;
      prev_txd  = tx_data;
      prev_done = cmd_done;
      prev_err  = cmd_err;
    end
  end

  task automatic start_cmd(input logic op, input int base, input int len, input int seed);
    int   k = 0;
    logic acc = 1'b0;
    if (base + len <= 1024) begin
      for (int w = 0; w < len; w++) begin
        for (int s = 0; s < 2; s++) begin
          int         b;
          logic [7:0] v;
          b = (base + w) * 2 + s;
          if (op == OP_LOAD) begin
            wr_t e;
            v = 8'(seed + k * 17);
            model_mem[b] = v;
            e.a = 10'(base + w);
            e.s = s[0];
            e.d = v;
            exp_wr.push_back(e);
            rx_q.push_back(v);
          end else begin
            exp_rd.push_back(11'(b));
            exp_tx.push_back(model_mem[b]);
          end
          k++;
        end
      end
    end
    cmd_op    = op;
    cmd_base  = 10'(base);
    cmd_len   = 11'(len);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'(1));
  endtask

  task automatic run_cmd(input logic op, input int base, input int len, input int seed, input int budget);
    int d0, e0;
    logic illegal;
    d0 = done_seen;
    e0 = err_seen;
    illegal = (base + len > 1024);
    start_cmd(op, base, len, seed);
    for (int i = 0; i < budget && done_seen == d0 && err_seen == e0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("done_count", 32'(done_seen - d0), illegal ? 32'(0) : 32'(1));
    check("err_count", 32'(err_seen - e0), illegal ? 32'(1) : 32'(0));
    check("wr_drained", 32'(exp_wr.size()), 32'(0));
    check("rd_drained", 32'(exp_rd.size()), 32'(0));
    check("tx_drained", 32'(exp_tx.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0;
    logic [7:0] lit [4];
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_flags", 32'({cmd_done, cmd_err, rx_ready, tx_valid}), 32'(0));
    check("rst_strobes", 32'({ub_we, ub_re, ub_fifo_en, ub_section}), 32'(0));
    check("rst_addr", 32'(ub_address), 32'(0));
    check("rst_data", 32'({ub_fifo_in, tx_data}), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'(1));

    // load base=5 len=2 bytes 11,22,33,44
    run_cmd(OP_LOAD, 5, 2, 8'h11, 200);
    check("mem5", 32'({bm_mem[11], bm_mem[10]}), 32'(16'h2211));
    check("mem6", 32'({bm_mem[13], bm_mem[12]}), 32'(16'h4433));

    // dump it back with a 3-cycle stall on every byte
    stall = 3;
    tx_seen.delete();
    run_cmd(OP_DUMP, 5, 2, 0, 300);
    check("tx_count", 32'(tx_seen.size()), 32'(4));
    for (int i = 0; i < 4; i++) check("tx_literal", 32'(tx_seen.size() > i ? tx_seen[i] : 8'hxx), 32'(lit[i]));
    stall = 0;

    // out-of-range command
    w0 = we_count; r0 = re_count;
    run_cmd(OP_LOAD, 1020, 5, 0, 50);
    check("err_ready", 32'(cmd_ready), 32'(1));
    check("err_no_wr", 32'(we_count - w0), 32'(0));
    check("err_no_rd", 32'(re_count - r0), 32'(0));
    run_cmd(OP_DUMP, 1023, 2, 0, 50);

    // zero-length command
    w0 = we_count; r0 = re_count;
    run_cmd(OP_LOAD, 0, 0, 0, 50);
    check("len0_no_wr", 32'(we_count - w0), 32'(0));
    check("len0_no_rd", 32'(re_count - r0), 32'(0));

    // full-buffer load
    w0 = we_count;
    run_cmd(OP_LOAD, 0, 1024, 3, 10000);
    check("full_writes", 32'(we_count - w0), 32'(2048));
    check("full_last_addr", 32'(last_wa), 32'(1023));
    check("full_last_sec", 32'(last_ws), 32'(1));
    stall = 1;
    run_cmd(OP_DUMP, 1022, 2, 0, 200);
    stall = 0;

    // slow buffer acknowledge
    done_delay = 4;
    run_cmd(OP_LOAD, 200, 2, 8'h5A, 300);
    check("slow_overlap", 32'(overlap), 32'(0));
    check("slow_mem200", 32'(bm_mem[400]), 32'(8'h5A));
    done_delay = 1;

    // reset while waiting for the acknowledge of word 2's low byte
    d0 = done_seen;
    w0 = we_count;
    start_cmd(OP_LOAD, 100, 4, 8'h40);
    for (int i = 0; i < 200 && we_count < w0 + 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reached", 32'(we_count - w0), 32'(3));
    rst = 1'b1;
    rx_q.delete();
    @(posedge clk);
    #1;
    check("abort_strobes", 32'({ub_we, ub_re, ub_fifo_en}), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rx_ready", 32'(rx_ready), 32'(0));
    rst = 1'b0;
    exp_wr.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(done_seen - d0), 32'(0));
    check("abort_no_wr", 32'(we_count - w0), 32'(3));
    run_cmd(OP_LOAD, 300, 1, 8'h77, 200);
    check("after_abort_mem", 32'({bm_mem[601], bm_mem[600]}), 32'(16'h8877));

    check("overlap_total", 32'(overlap), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
